// File: rtl/exp_neg_iter.sv
// Sequential exp(-y) in signed QW.QF fixed point.
// Range reduction y = k*ln2 + r, then a Horner Taylor series on r, then a 2^-k shift.
module exp_neg_iter #(
    parameter int QW      = 32,
    parameter int QF      = 16,
    parameter int N_TERMS = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [QW-1:0] y_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW-1:0] y_out,
    output logic          uflow,
    output logic          neg_in
);

    localparam int W2  = 2 * QW;
    localparam int SHW = $clog2(QW);

    localparam real LN2_R = 0.6931471805599453;
    localparam logic signed [QW-1:0] ONE     = QW'(64'd1 << QF);
    localparam logic signed [QW-1:0] LN2     = QW'($rtoi(LN2_R * (2.0 ** QF) + 0.5));
    localparam logic signed [QW-1:0] INV_LN2 = QW'($rtoi((2.0 ** QF) / LN2_R + 0.5));
    localparam logic signed [QW-1:0] K_MAX   = QW'(QW - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] REDUCE = 3'd1;
    localparam logic [2:0] POLY   = 3'd2;
    localparam logic [2:0] SCALE  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    // round(ONE / i); entry 0 is never indexed but keeps the table 16 deep
    function automatic logic signed [QW-1:0] recip_val(input int i);
        longint num;
        if (i == 0) return '0;
        num = (longint'(1) << QF) + longint'(i / 2);
        return QW'(num / longint'(i));
    endfunction

    logic signed [QW-1:0] recip_tab [0:15];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_recip
            assign recip_tab[gi] = recip_val(gi);
        end
    endgenerate

    logic [2:0]           state_reg;
    logic signed [QW-1:0] y_reg;
    logic                 neg_reg;
    logic signed [QW-1:0] k_reg;
    logic signed [QW-1:0] r_reg;
    logic signed [QW-1:0] acc_reg;
    logic [3:0]           cnt_reg;

    // Range reduction: INV_LN2 rounds down, so k never overshoots and r stays >= 0
    logic signed [W2-1:0] prod_k;
    logic signed [QW-1:0] k0;
    logic signed [W2-1:0] prod_kl;
    logic signed [QW-1:0] r0;
    logic signed [QW-1:0] k_next;
    logic signed [QW-1:0] r_next;

    assign prod_k  = W2'(y_reg) * W2'(INV_LN2);
    assign k0      = QW'(prod_k >>> (2 * QF));
    assign prod_kl = W2'(k0) * W2'(LN2);
    assign r0      = y_reg - QW'(prod_kl);

    always_comb begin
        k_next = k0;
        r_next = r0;
        if (r0 >= LN2) begin
            k_next = k0 + QW'(1);
            r_next = r0 - LN2;
        end
    end

    // One Horner step: acc = 1 - (r*acc) / i
    logic signed [W2-1:0] prod_ra;
    logic signed [W2-1:0] prod_rr;
    logic signed [QW-1:0] acc_step;

    assign prod_ra  = W2'(r_reg) * W2'(acc_reg);
    assign prod_rr  = (prod_ra >>> QF) * W2'(recip_tab[cnt_reg]);
    assign acc_step = ONE - QW'(prod_rr >>> QF);

    logic signed [QW-1:0] acc_clamp;
    logic signed [QW-1:0] acc_scaled;

    always_comb begin
        acc_clamp = acc_reg;
        if (acc_reg < 0)
            acc_clamp = '0;
        else if (acc_reg > ONE)
            acc_clamp = ONE;
    end

    assign acc_scaled = acc_clamp >>> k_reg[SHW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            y_reg     <= '0;
            neg_reg   <= 1'b0;
            k_reg     <= '0;
            r_reg     <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            y_out     <= '0;
            uflow     <= 1'b0;
            neg_in    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        y_reg     <= y_in[QW-1] ? '0 : $signed(y_in);
                        neg_reg   <= y_in[QW-1];
                        state_reg <= REDUCE;
                    end
                end
                REDUCE: begin
                    k_reg     <= k_next;
                    r_reg     <= r_next;
                    acc_reg   <= ONE;
                    cnt_reg   <= 4'(N_TERMS);
                    state_reg <= POLY;
                end
                POLY: begin
                    acc_reg <= acc_step;
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1)
                        state_reg <= SCALE;
                end
                SCALE: begin
                    if (k_reg >= K_MAX) begin
                        y_out <= '0;
                        uflow <= 1'b1;
                    end else begin
                        y_out <= acc_scaled;
                        uflow <= 1'b0;
                    end
                    neg_in    <= neg_reg;
                    state_reg <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);

endmodule

// File: tb/tb_exp_neg_iter.sv
// Bench for exp_neg_iter: directed cases, handshake/reset checks and a random sweep
// compared against a real-valued exp() model.
module tb_exp_neg_iter;

    localparam int  QW  = 32;
    localparam int  QF  = 16;
    localparam int  NT  = 6;
    localparam int  LAT = NT + 2;
    localparam real TOL = 8.0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [QW-1:0] y_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [QW-1:0] y_out;
    logic          uflow;
    logic          neg_in;

    int n_checks = 0;
    int n_fail   = 0;

    exp_neg_iter #(.QW(QW), .QF(QF), .N_TERMS(NT)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y_in     (y_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y_out    (y_out),
        .uflow    (uflow),
        .neg_in   (neg_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: exp(-y) scaled by ONE, negative inputs clamped to 0
    function automatic real model(input logic [QW-1:0] y);
        real yr;
        yr = $signed(y) < 0 ? 0.0 : real'($signed(y)) / 65536.0;
        return $exp(-yr) * 65536.0;
    endfunction

    task automatic chk_tol(input string tag, input logic [QW-1:0] y, input logic [QW-1:0] obs);
        real ref_v, d;
        ref_v = model(y);
        d = real'(obs) - ref_v;
        if (d < 0.0) d = -d;
        n_checks++;
        assert (d <= TOL) else begin
            n_fail++;
            $error("FAIL %s: y=%0h observed %0d expected %0.2f +-8", tag, y, obs, ref_v);
        end
    endtask

    // Launch one op; returns cycles from the in_fire edge to out_valid (-1 on timeout).
    task automatic do_op(input logic [QW-1:0] y, output int lat);
        int guard;
        @(negedge clk);
        in_valid = 1'b1;
        y_in = y;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid || guard >= 50) lat = -1;
    endtask

    task automatic ack();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [QW-1:0] y, held;
        logic hu, hn;

        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_y_out", y_out, 0);
        chk("rst_uflow", uflow, 0);
        chk("rst_neg_in", neg_in, 0);
        @(negedge clk);
        rst = 1'b0;

        // y = 0 -> exactly ONE, latency N_TERMS+2
        do_op(32'h0000_0000, lat);
        chk("zero_latency", lat, LAT);
        chk("zero_y_out", y_out, 32'h0001_0000);
        chk("zero_uflow", uflow, 0);
        chk("zero_neg_in", neg_in, 0);
        $display("op y=%08h y_out=%08h uflow=%0d neg=%0d lat=%0d", 32'h0, y_out, uflow, neg_in, lat);
        ack();

        do_op(32'h0001_0000, lat);
        chk_tol("one", 32'h0001_0000, y_out);
        chk("one_y_out_window", (y_out >= 24101 && y_out <= 24117) ? 1 : 0, 1);
        $display("op y=%08h y_out=%0d", 32'h0001_0000, y_out);
        ack();

        do_op(32'h0000_B172, lat);
        chk_tol("ln2", 32'h0000_B172, y_out);
        $display("op y=%08h y_out=%0d", 32'h0000_B172, y_out);
        ack();

        do_op(32'h0005_0000, lat);
        chk_tol("five", 32'h0005_0000, y_out);
        chk("five_uflow", uflow, 0);
        $display("op y=%08h y_out=%0d", 32'h0005_0000, y_out);
        ack();

        do_op(32'h7FFF_0000, lat);
        chk("big_y_out", y_out, 0);
        chk("big_uflow", uflow, 1);
        $display("op y=%08h y_out=%0d uflow=%0d", 32'h7FFF_0000, y_out, uflow);
        ack();

        do_op(32'hFFFF_0000, lat);
        chk("neg1_y_out", y_out, 32'h0001_0000);
        chk("neg1_neg_in", neg_in, 1);
        chk("neg1_uflow", uflow, 0);
        $display("op y=%08h y_out=%08h neg=%0d", 32'hFFFF_0000, y_out, neg_in);
        ack();

        do_op(32'h8000_0000, lat);
        chk("minneg_y_out", y_out, 32'h0001_0000);
        chk("minneg_neg_in", neg_in, 1);
        $display("op y=%08h y_out=%08h neg=%0d", 32'h8000_0000, y_out, neg_in);
        ack();

        // Backpressure: hold out_ready low, outputs stay put
        do_op(32'h0002_0000, lat);
        chk("bp_latency", lat, LAT);
        held = y_out; hu = uflow; hn = neg_in;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_y_out", y_out, held);
            chk("bp_flags", {uflow, neg_in}, {hu, hn});
        end
        chk_tol("bp_value", 32'h0002_0000, held);
        ack();
        chk("bp_in_ready_after", in_ready, 1);
        chk("bp_out_valid_after", out_valid, 0);
        $display("op y=%08h y_out=%0d held 5 cycles", 32'h0002_0000, held);

        // Reset during POLY aborts the op
        @(negedge clk);
        in_valid = 1'b1;
        y_in = 32'h0003_0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < LAT + 4; c++) begin
            @(posedge clk);
            #1;
            chk("abort_no_output", out_valid, 0);
        end
        chk("abort_in_ready_rel", in_ready, 1);
        $display("op reset during POLY: no output produced");

        do_op(32'h0001_0000, lat);
        chk("post_rst_latency", lat, LAT);
        chk_tol("post_rst_one", 32'h0001_0000, y_out);
        $display("op y=%08h y_out=%0d after reset", 32'h0001_0000, y_out);
        ack();

        // Random sweep over [0, 20.0]
        for (int n = 0; n < 1000; n++) begin
            y = $urandom_range(0, 20 * 65536);
            do_op(y, lat);
            chk("rnd_latency", lat, LAT);
            chk_tol("rnd_value", y, y_out);
            chk("rnd_flags", {uflow, neg_in}, 2'b00);
            if (n < 10) $display("op y=%08h y_out=%0d ref=%0.2f", y, y_out, model(y));
            ack();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
